// File: rtl/uart_tx_ext.sv
// Parametrised UART transmitter with an input FIFO: configurable data width,
// parity mode and stop-bit count, frames sent back-to-back while words are queued.
module uart_tx_ext #(
    parameter int F          = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic [2:0]        o_state
);

    localparam int N  = (F + BAUD / 2) / BAUD;
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(DATA_W);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_next;

    logic              bit_done;
    logic              stop_done;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              tx_bit;
    logic [DATA_W-1:0] head;

    // Handshake: a word is accepted on a rising edge where i_valid and o_ready
    // are both high; o_ready is registered and never high while the FIFO is full.
    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign bit_done   = (cnt == CW'(N - 1));
    assign stop_done  = (state == S_STOP) && bit_done && (idx == IW'(STOP_BITS - 1));
    assign push       = i_valid && o_ready && !i_rst;
    assign pop        = !fifo_empty && ((state == S_IDLE) || stop_done);
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign o_state    = state;

    always_comb begin
        tx_bit = 1'b1;
        case (state)
            S_START:  tx_bit = 1'b0;
            S_DATA:   tx_bit = shreg[0];
            S_PARITY: tx_bit = par_bit;
            default:  tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    // The line and busy flag are registered from the current state, so every
    // bit appears on o_tx one edge after the FSM enters it, uniformly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_tx    <= 1'b1;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            count   <= count_next;
            o_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
            o_tx    <= tx_bit;
            o_busy  <= (state != S_IDLE) || !fifo_empty;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                shreg   <= head;
                par_bit <= (^head) ^ (PARITY == 1);
            end
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (pop) state <= S_START;
                end
                S_START: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        shreg <= shreg >> 1;
                        if (idx == IW'(DATA_W - 1)) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (idx == IW'(STOP_BITS - 1)) begin
                            idx   <= '0;
                            state <= pop ? S_START : S_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Directed bench for uart_tx_ext: five configurations (8N1, 8E1, 8O1, 7N2, 9E1)
// at N=8 cycles per bit, checking frames, latency, FIFO back-pressure and reset.
module tb_uart_tx_ext;

    localparam int F    = 921600;
    localparam int BAUD = 115200;
    localparam int N    = 8;

    logic       clk;
    logic       rst;
    logic [8:0] din [5];
    logic       vin [5];
    logic       rdy [5];
    logic       txo [5];
    logic       bsy [5];
    logic [2:0] st  [5];

    int n_checks;
    int n_errors;
    int cyc;
    int acc [6];

    uart_tx_ext #(.F(F), .BAUD(BAUD), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .i_clk(clk), .i_rst(rst), .i_data(din[0][7:0]), .i_valid(vin[0]),
        .o_ready(rdy[0]), .o_tx(txo[0]), .o_busy(bsy[0]), .o_state(st[0]));
    uart_tx_ext #(.F(F), .BAUD(BAUD), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .i_clk(clk), .i_rst(rst), .i_data(din[1][7:0]), .i_valid(vin[1]),
        .o_ready(rdy[1]), .o_tx(txo[1]), .o_busy(bsy[1]), .o_state(st[1]));
    uart_tx_ext #(.F(F), .BAUD(BAUD), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .i_clk(clk), .i_rst(rst), .i_data(din[2][7:0]), .i_valid(vin[2]),
        .o_ready(rdy[2]), .o_tx(txo[2]), .o_busy(bsy[2]), .o_state(st[2]));
    uart_tx_ext #(.F(F), .BAUD(BAUD), .DATA_W(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .i_clk(clk), .i_rst(rst), .i_data(din[3][6:0]), .i_valid(vin[3]),
        .o_ready(rdy[3]), .o_tx(txo[3]), .o_busy(bsy[3]), .o_state(st[3]));
    uart_tx_ext #(.F(F), .BAUD(BAUD), .DATA_W(9), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_data(din[4]), .i_valid(vin[4]),
        .o_ready(rdy[4]), .o_tx(txo[4]), .o_busy(bsy[4]), .o_state(st[4]));

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; the word is accepted on the following posedge and
    // the task returns on the negedge after it.
    task automatic push(input int idx, input logic [8:0] w);
        chk($sformatf("u%0d ready before push", idx), 32'(rdy[idx]), 32'd1);
        din[idx] = w;
        vin[idx] = 1'b1;
        @(negedge clk);
        vin[idx] = 1'b0;
    endtask

    // Checks one full frame on o_tx, one comparison per cycle, starting at the
    // next negedge (the first start-bit cycle).
    task automatic frame(input int idx, input logic [8:0] w, input int dw,
                         input bit has_par, input bit pbit, input int sb);
        logic [11:0] bits;
        int nb;
        bits = '0;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < dw; i++) begin
            bits[nb] = w[i]; nb++;
        end
        if (has_par) begin
            bits[nb] = pbit; nb++;
        end
        for (int i = 0; i < sb; i++) begin
            bits[nb] = 1'b1; nb++;
        end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < N; c++) begin
                @(negedge clk);
                chk($sformatf("u%0d word %0h bit %0d cyc %0d", idx, w, b, c),
                    32'(txo[idx]), 32'(bits[b]));
            end
        end
    endtask

    task automatic single(input int idx, input logic [8:0] w, input int dw,
                          input bit has_par, input bit pbit, input int sb);
        push(idx, w);
        @(negedge clk);
        chk($sformatf("u%0d idle before start", idx), 32'(txo[idx]), 32'd1);
        chk($sformatf("u%0d busy after push", idx), 32'(bsy[idx]), 32'd1);
        frame(idx, w, dw, has_par, pbit, sb);
        chk($sformatf("u%0d busy at last stop cycle", idx), 32'(bsy[idx]), 32'd1);
        @(negedge clk);
        chk($sformatf("u%0d busy falls", idx), 32'(bsy[idx]), 32'd0);
        chk($sformatf("u%0d idle after frame", idx), 32'(txo[idx]), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din[i] = '0;
            vin[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("u%0d reset tx", i), 32'(txo[i]), 32'd1);
            chk($sformatf("u%0d reset ready", i), 32'(rdy[i]), 32'd0);
            chk($sformatf("u%0d reset busy", i), 32'(bsy[i]), 32'd0);
            chk($sformatf("u%0d reset state", i), 32'(st[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            chk($sformatf("u%0d ready after reset", i), 32'(rdy[i]), 32'd1);

        // 8N1 0xA5, 8E1/8O1 0x07, 9E1 0x1FF with hand-computed parity bits
        single(0, 9'h0A5, 8, 1'b0, 1'b0, 1);
        single(1, 9'h007, 8, 1'b1, 1'b1, 1);
        single(2, 9'h007, 8, 1'b1, 1'b0, 1);
        single(4, 9'h1FF, 9, 1'b1, 1'b1, 1);

        // 7N2 two words queued: second start follows the first by exactly 80 cycles
        push(3, 9'h041);
        push(3, 9'h02A);
        chk("u3 idle before start", 32'(txo[3]), 32'd1);
        frame(3, 9'h041, 7, 1'b0, 1'b0, 2);
        frame(3, 9'h02A, 7, 1'b0, 1'b0, 2);
        chk("u3 busy at last stop cycle", 32'(bsy[3]), 32'd1);
        @(negedge clk);
        chk("u3 busy falls", 32'(bsy[3]), 32'd0);

        // Hold i_valid across six words into a 4-deep FIFO on 8N1
        fork
            begin
                vin[0] = 1'b1;
                for (int j = 0; j < 6; j++) begin
                    int waits;
                    din[0] = 9'(9'h011 + j);
                    waits = 0;
                    while (!rdy[0] && waits < 200) begin
                        @(negedge clk);
                        waits++;
                    end
                    chk($sformatf("word %0d ready within bound", j), 32'(rdy[0]), 32'd1);
                    @(negedge clk);
                    acc[j] = cyc;
                end
                vin[0] = 1'b0;
            end
            begin
                @(negedge clk);
                @(negedge clk);
                chk("u0 fifo idle before start", 32'(txo[0]), 32'd1);
                for (int j = 0; j < 6; j++)
                    frame(0, 9'(9'h011 + j), 8, 1'b0, 1'b0, 1);
                @(negedge clk);
                chk("u0 fifo busy falls", 32'(bsy[0]), 32'd0);
            end
        join
        for (int j = 1; j < 5; j++)
            chk($sformatf("accept edge word %0d", j), 32'(acc[j] - acc[0]), 32'(j));
        // FIFO full after the 5th word; ready rises on the edge word 2 pops
        // (k+81) and the 6th word is taken on the following edge.
        chk("accept edge word 5", 32'(acc[5] - acc[0]), 32'd82);

        // Reset during data bit 3 of 0x08 with two more words queued
        push(0, 9'h008);
        push(0, 9'h0F0);
        push(0, 9'h00F);
        repeat (34) @(negedge clk);
        chk("pre-reset state DATA", 32'(st[0]), 32'd2);
        chk("pre-reset data bit 3", 32'(txo[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-frame reset tx", 32'(txo[0]), 32'd1);
        chk("mid-frame reset busy", 32'(bsy[0]), 32'd0);
        chk("mid-frame reset ready", 32'(rdy[0]), 32'd0);
        chk("mid-frame reset state", 32'(st[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after mid-frame reset", 32'(rdy[0]), 32'd1);
        single(0, 9'h03C, 8, 1'b0, 1'b0, 1);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk($sformatf("no stale frame cyc %0d", c), 32'(txo[0]), 32'd1);
        end
        chk("no stale busy", 32'(bsy[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
